// File: rtl/dmem_responder.sv
// Multi-cycle data memory responder for the memory stage.
// Byte-lane stores, range/alignment checks, fixed access latency.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_be;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_access;
    logic          w_acc_we;
    logic [3:0]    w_acc_be;
    logic [31:0]   w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic          w_acc_err;
    logic [AW-1:0] w_idx;

    assign w_accept = (r_state == IDLE) && req_valid;

    // Zero latency accesses on the accept edge with the live inputs.
    assign w_access = ((r_state == WAIT) && (r_cnt == 4'd0))
                    || ((LATENCY == 0) && w_accept);

    assign w_acc_we    = (r_state == IDLE) ? req_we    : r_we;
    assign w_acc_be    = (r_state == IDLE) ? req_be    : r_be;
    assign w_acc_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

    assign w_acc_err = (w_acc_addr[1:0] != 2'b00)
                     || ({2'b00, w_acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign w_idx = w_acc_addr[AW+1:2];

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: if (req_valid) w_next = (LATENCY == 0) ? RESP : WAIT;
            WAIT: if (r_cnt == 4'd0) w_next = RESP;
            RESP: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_be    <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_we    <= req_we;
                r_be    <= req_be;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_err   <= w_acc_err;
                r_rdata <= (!w_acc_we && !w_acc_err) ? r_mem[w_idx] : 32'd0;
            end
        end
    end

    // Array is not reset; rst gates the write so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (rst && w_access && w_acc_we && !w_acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: four instances at latencies 2, 0, 4, 15.
// Scoreboard-checked responses plus cycle-exact timing sequences.
module tb_dmem_responder;

    localparam int NI = 4;

    logic        clk;
    logic        rst       [NI];
    logic        req_valid [NI];
    logic        req_ready [NI];
    logic        req_we    [NI];
    logic [3:0]  req_be    [NI];
    logic [31:0] req_addr  [NI];
    logic [31:0] req_wdata [NI];
    logic        rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        rsp_err   [NI];
    logic        busy      [NI];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          inst;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    vec_t vt[16];

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_be(req_be[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) u_l0 (
        .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_be(req_be[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we[2]), .req_be(req_be[2]), .req_addr(req_addr[2]),
        .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
        .rsp_err(rsp_err[2]), .busy(busy[2]));

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(15)) u_l15 (
        .clk(clk), .rst(rst[3]), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
        .req_we(req_we[3]), .req_be(req_be[3]), .req_addr(req_addr[3]),
        .req_wdata(req_wdata[3]), .rsp_valid(rsp_valid[3]), .rsp_rdata(rsp_rdata[3]),
        .rsp_err(rsp_err[3]), .busy(busy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the queue head.
    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (rsp_valid[k] === 1'b1) begin
                n_tests++;
                if (sb.size() == 0 || sb[0].inst != k) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp inst %0d: got rdata=%h err=%b required no response",
                             k, rsp_rdata[k], rsp_err[k]);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rsp_rdata[k] !== e.rdata || rsp_err[k] !== e.err) begin
                        n_fail++;
                        $display("FAIL rsp inst %0d: got rdata=%h err=%b required rdata=%h err=%b",
                                 k, rsp_rdata[k], rsp_err[k], e.rdata, e.err);
                    end
                end
            end
        end
    end

    task automatic drain();
        int g = 0;
        while (sb.size() != 0 && g < 40) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got %0d pending responses required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_idle(int k);
        int g = 0;
        @(negedge clk);
        while (req_ready[k] !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk($sformatf("ready_wait_%0d", k), 64'(req_ready[k]), 64'd1);
    endtask

    task automatic do_req(vec_t v);
        int k = v.inst;
        wait_idle(k);
        req_we[k]    = v.we;
        req_be[k]    = v.be;
        req_addr[k]  = v.addr;
        req_wdata[k] = v.wdata;
        req_valid[k] = 1'b1;
        sb.push_back('{inst: k, rdata: v.rdata, err: v.err});
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        req_we[k]    = ~v.we;
        req_be[k]    = 4'($urandom);
        req_addr[k]  = $urandom;
        req_wdata[k] = $urandom;
        drain();
    endtask

    // Single accept: exact pulse position, busy window and ready return.
    task automatic timing_seq(int k, int lat);
        wait_idle(k);
        req_we[k]    = 1'b1;
        req_be[k]    = 4'b0000;
        req_addr[k]  = 32'h0;
        req_wdata[k] = 32'h0;
        req_valid[k] = 1'b1;
        sb.push_back('{inst: k, rdata: 32'h0, err: 1'b0});
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        for (int s = 0; s <= lat + 2; s++) begin
            @(negedge clk);
            chk($sformatf("timing_l%0d_s%0d", lat, s),
                64'({rsp_valid[k], busy[k], req_ready[k]}),
                64'({s == lat, s <= lat, s > lat}));
        end
        drain();
    endtask

    // Three requests with req_valid held high must finish in 3*(lat+2) cycles.
    task automatic b2b_seq(int k, int lat);
        int p = lat + 2;
        int bad = 0;
        int pulses = 0;
        wait_idle(k);
        req_we[k]    = 1'b1;
        req_be[k]    = 4'b0000;
        req_addr[k]  = 32'h0;
        req_wdata[k] = 32'h0;
        req_valid[k] = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back('{inst: k, rdata: 32'h0, err: 1'b0});
        for (int s = 0; s < 3 * p; s++) begin
            @(negedge clk);
            if (req_ready[k] !== ((s % p) == p - 1)) bad++;
            if (rsp_valid[k] !== ((s % p) == lat)) bad++;
            if (rsp_valid[k] === 1'b1) pulses++;
        end
        req_valid[k] = 1'b0;
        chk($sformatf("b2b_l%0d_pattern_errs", lat), 64'(bad), 64'd0);
        chk($sformatf("b2b_l%0d_pulses", lat), 64'(pulses), 64'd3);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{0, 1'b1, 4'hF, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
        vt[1]  = '{0, 1'b0, 4'h0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
        vt[2]  = '{0, 1'b1, 4'h5, 32'h10,  32'h11223344, 32'h0,        1'b0};
        vt[3]  = '{0, 1'b0, 4'hF, 32'h10,  32'h0,        32'hDE22BE44, 1'b0};
        vt[4]  = '{0, 1'b1, 4'h0, 32'h10,  32'hFFFFFFFF, 32'h0,        1'b0};
        vt[5]  = '{0, 1'b0, 4'h0, 32'h10,  32'h0,        32'hDE22BE44, 1'b0};
        vt[6]  = '{0, 1'b1, 4'hF, 32'h0,   32'h12345678, 32'h0,        1'b0};
        vt[7]  = '{0, 1'b0, 4'h0, 32'h13,  32'h0,        32'h0,        1'b1};
        vt[8]  = '{0, 1'b1, 4'hF, 32'h1000,32'hAAAAAAAA, 32'h0,        1'b1};
        vt[9]  = '{0, 1'b0, 4'h0, 32'h0,   32'h0,        32'h12345678, 1'b0};
        vt[10] = '{0, 1'b1, 4'hF, 32'hFFC, 32'h0BADCAFE, 32'h0,        1'b0};
        vt[11] = '{0, 1'b0, 4'h0, 32'hFFC, 32'h0,        32'h0BADCAFE, 1'b0};
        vt[12] = '{1, 1'b1, 4'hF, 32'h40,  32'h55AA55AA, 32'h0,        1'b0};
        vt[13] = '{1, 1'b0, 4'h0, 32'h40,  32'h0,        32'h55AA55AA, 1'b0};
        vt[14] = '{3, 1'b1, 4'hA, 32'h8,   32'h01020304, 32'h0,        1'b0};
        vt[15] = '{3, 1'b1, 4'h0, 32'h2,   32'h0,        32'h0,        1'b1};

        for (int k = 0; k < NI; k++) begin
            rst[k]       = 1'b0;
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_be[k]    = 4'h0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
        end
        #3;
        for (int k = 0; k < NI; k++)
            chk($sformatf("reset_outputs_%0d", k),
                64'({req_ready[k], busy[k], rsp_valid[k], rsp_err[k], rsp_rdata[k]}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
        @(negedge clk);
        for (int k = 0; k < NI; k++) rst[k] = 1'b1;

        for (int i = 0; i < 16; i++) do_req(vt[i]);

        // Asynchronous reset while an errored load is in RESP.
        wait_idle(0);
        req_we[0]    = 1'b0;
        req_addr[0]  = 32'h13;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("pre_reset_resp", 64'({rsp_valid[0], rsp_err[0]}), 64'({1'b1, 1'b1}));
        #1;
        rst[0] = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({req_ready[0], busy[0], rsp_valid[0], rsp_err[0], rsp_rdata[0]}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'h0}));
        @(negedge clk);
        rst[0] = 1'b1;

        timing_seq(0, 2);
        timing_seq(1, 0);
        timing_seq(3, 15);
        b2b_seq(0, 2);
        b2b_seq(1, 0);

        // Reset two cycles into WAIT must drop the pending store.
        do_req('{2, 1'b1, 4'hF, 32'h20, 32'h0, 32'h0, 1'b0});
        wait_idle(2);
        req_we[2]    = 1'b1;
        req_be[2]    = 4'hF;
        req_addr[2]  = 32'h20;
        req_wdata[2] = 32'hCAFEF00D;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst[2] = 1'b0;
        #1;
        chk("wait_reset_outputs", 64'({req_ready[2], busy[2], rsp_valid[2]}),
            64'({1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        rst[2] = 1'b1;
        begin
            int pulses = 0;
            for (int s = 0; s < 8; s++) begin
                @(negedge clk);
                if (rsp_valid[2] === 1'b1) pulses++;
            end
            chk("wait_reset_no_rsp", 64'(pulses), 64'd0);
        end
        do_req('{2, 1'b0, 4'h0, 32'h20, 32'h0, 32'h0, 1'b0});

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder that services load/store requests issued by the pipeline's memory stage over a valid/ready request channel and a one-cycle response pulse. It holds the word-addressed data array, applies byte-lane write enables, flags misaligned and out-of-range accesses, and models a fixed access latency so the hazard and stall logic can be exercised against a slow memory. It sits between the memory-stage initiator and the writeback pipeline register.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; legal word index 0..DEPTH_WORDS-1.
- LATENCY, 2: wait cycles between request acceptance and access; legal range 0..15.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_be  in  4  byte-lane enables for stores; bit i covers wdata[8i+7:8i]; ignored for loads.
- req_addr  in  32  byte address; word index = req_addr[31:2].
- req_wdata  in  32  store data.
- rsp_valid  out  1  one-cycle pulse: response is valid.
- rsp_rdata  out  32  load data; 0 for stores and errored accesses.
- rsp_err  out  1  access rejected (misaligned or out of range); qualified by rsp_valid.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid at a rising edge (accept), capture we, be, addr and wdata into internal registers. Requester inputs are don't-care after acceptance.
- Accept with LATENCY=0: go directly to RESP and perform the access on the same edge using the live inputs.
- Accept with LATENCY>0: go to WAIT and load the counter with LATENCY-1.
- WAIT: decrement the counter each cycle. At counter=0, go to RESP and perform the access on that edge using the captured values.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE. No request is accepted in RESP.
- Error check when the access is performed:
  - err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH_WORDS).
  - On error: no array write, rsp_rdata=0, rsp_err=1.
- Store with no error: for each i with be[i]=1, write byte lane i. Lanes with be[i]=0 are unchanged. be=4'b0000 is a legal no-op that still responds. rsp_rdata=0, rsp_err=0.
- Load with no error: rsp_rdata = the full word at the index, registered on the access edge. rsp_err=0.
- Data array is not cleared by reset; contents are undefined until written.
- Read-after-write: a load accepted after a store's response observes the stored bytes.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, all capture registers 0.
- Accept at edge E: rsp_valid is high in the cycle following edge E+LATENCY, and low again after edge E+LATENCY+1.
- req_ready is low from after edge E until after edge E+LATENCY+1. Maximum throughput is one request per LATENCY+2 cycles.
- rsp_rdata and rsp_err hold their values outside the rsp_valid pulse; consumers qualify them with rsp_valid.
- Reset during WAIT or RESP: the in-flight request is aborted. A store in WAIT is never committed. A store already committed on the RESP-entry edge stays committed. No rsp_valid is produced after reset release.
- req_valid held high in RESP is not accepted until the next IDLE edge; the requester keeps its request stable until it sees req_ready.
- Counter width is 4 bits; LATENCY=15 must not wrap early.

## Test plan
- Reset, LATENCY=2: assert rst=0 mid-cycle -> outputs immediately at reset values. Release, then store addr=0x10, be=4'hF, wdata=0xDEADBEEF -> rsp_valid exactly 3 cycles after accept, rsp_err=0, rsp_rdata=0. Load 0x10 -> rsp_rdata=0xDEADBEEF.
- Byte lanes: after 0xDEADBEEF at 0x10, store be=4'b0101, wdata=0x11223344 -> load 0x10 returns 0xDE22BE44. Store with be=0 -> word unchanged, rsp_valid still pulses.
- Errors: load 0x13 -> rsp_err=1, rsp_rdata=0. Store to byte address 4*DEPTH_WORDS (0x1000 at default) -> rsp_err=1, and a load of 0x0 is unchanged.
- Back-to-back with req_valid held high: req_ready low for LATENCY+1 cycles after each accept; 3 requests complete in exactly 3*(LATENCY+2) cycles. Repeat with LATENCY=0: pulse on the cycle after accept, one request per 2 cycles.
- Reset mid-WAIT, LATENCY=4: store 0x20 = 0xCAFEF00D, reset 2 cycles after accept -> no rsp_valid. Load 0x20 returns the prior value, 0x00000000 written beforehand.
- LATENCY=15: accept -> rsp_valid exactly 16 cycles later; busy high for exactly 16 cycles.
